// File: rtl/fetch_stage_pkg.sv
// Shared MIPS constants for the fetch stage, the instruction memory and the
// later pipeline stages.
// Contents:
//   INSTR_WIDTH      - instruction and address width
//   DEFAULT_RESET_PC - PC loaded at reset unless a stage overrides it
//   DEFAULT_NOP_WORD - instruction word used to fill bubbles
//   pc_sel_e         - next-PC source selection
//   word_align()     - clears the byte-offset bits of an address
package fetch_stage_pkg;

  localparam int INSTR_WIDTH = 32;

  localparam logic [INSTR_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_WIDTH-1:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  localparam logic [INSTR_WIDTH-1:0] PC_INCREMENT    = 32'd4;
  localparam logic [INSTR_WIDTH-1:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    PC_SEL_INC,
    PC_SEL_HOLD,
    PC_SEL_BRANCH
  } pc_sel_e;

  // Misaligned targets are silently forced onto a word boundary.
  function automatic logic [INSTR_WIDTH-1:0] word_align(input logic [INSTR_WIDTH-1:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register with its next-PC mux.
// Ports:
//   clk           - clock, rising edge
//   rst_n         - asynchronous active-low reset, loads RESET_PC
//   stall         - hold the PC
//   branch_taken  - redirect to branch_target (wins over stall)
//   branch_target - redirect byte address, word-aligned internally
//   pc            - current PC
//   pc_plus4      - pc + 4, modulo 2^32
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [INSTR_WIDTH-1:0] branch_target,
  output logic [INSTR_WIDTH-1:0] pc,
  output logic [INSTR_WIDTH-1:0] pc_plus4
);

  pc_sel_e pc_sel;

  // Wraps naturally at 32 bits: 32'hFFFFFFFC + 4 = 0.
  assign pc_plus4 = pc + PC_INCREMENT;

  // A redirect has priority over a stall so a branch resolved while the
  // front end is stalled is never lost.
  always_comb begin
    pc_sel = PC_SEL_INC;
    if (branch_taken) begin
      pc_sel = PC_SEL_BRANCH;
    end else if (stall) begin
      pc_sel = PC_SEL_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_SEL_INC:    pc <= pc_plus4;
        PC_SEL_HOLD:   pc <= pc;
        PC_SEL_BRANCH: pc <= word_align(branch_target);
        default:       pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// The instruction memory sits beside this block at the top level and is
// reached through Address / Instruction.
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   Stall         - hold PC and IF/ID
//   BranchTaken   - redirect to BranchTarget and insert one bubble
//   BranchTarget  - redirect byte address
//   Address       - current PC, straight from the PC register
//   Instruction   - word returned combinationally by the memory
//   IFID_Instr    - registered fetched instruction
//   IFID_PCPlus4  - registered PC+4 of IFID_Instr
//   IFID_Valid    - IFID_Instr is a real instruction, not a bubble
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [INSTR_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Stall,
  input  logic                   BranchTaken,
  input  logic [INSTR_WIDTH-1:0] BranchTarget,
  output logic [INSTR_WIDTH-1:0] Address,
  input  logic [INSTR_WIDTH-1:0] Instruction,
  output logic [INSTR_WIDTH-1:0] IFID_Instr,
  output logic [INSTR_WIDTH-1:0] IFID_PCPlus4,
  output logic                   IFID_Valid
);

  logic [INSTR_WIDTH-1:0] pc;
  logic [INSTR_WIDTH-1:0] pc_plus4;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (Stall),
    .branch_taken (BranchTaken),
    .branch_target(BranchTarget),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
  );

  assign Address = pc;

  // IF/ID register. Instruction is only sampled on a normal advance, so an
  // undriven memory output during a stall or redirect never reaches IF/ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IFID_Instr   <= NOP_WORD;
      IFID_PCPlus4 <= '0;
      IFID_Valid   <= 1'b0;
    end else if (BranchTaken) begin
      IFID_Instr   <= NOP_WORD;
      IFID_PCPlus4 <= '0;
      IFID_Valid   <= 1'b0;
    end else if (!Stall) begin
      IFID_Instr   <= Instruction;
      IFID_PCPlus4 <= pc_plus4;
      IFID_Valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/branch traffic, compared against a small behavioural model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;

  logic        xmode;

  int errors;
  int checks;

  // behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Address     (Address),
    .Instruction (Instruction),
    .IFID_Instr  (IFID_Instr),
    .IFID_PCPlus4(IFID_PCPlus4),
    .IFID_Valid  (IFID_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: five preloaded words, a distinct pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr / 4;
    case (idx)
      32'd0:   return 32'h2008_0005;
      32'd1:   return 32'h2009_0003;
      32'd2:   return 32'h0109_5020;
      32'd3:   return 32'hAC0A_0000;
      32'd4:   return 32'h0800_0000;
      default: return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  // X on the memory output whenever it must not be consumed.
  assign Instruction = xmode ? {32{1'bx}} : mem_word(Address);

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "/Address"}, Address, m_pc);
    checkValue({tag, "/IFID_Instr"}, IFID_Instr, m_instr);
    checkValue({tag, "/IFID_PCPlus4"}, IFID_PCPlus4, m_pc4);
    checkValue({tag, "/IFID_Valid"}, {31'd0, IFID_Valid}, {31'd0, m_valid});
  endtask

  task automatic modelReset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  // One clock cycle: drive inputs at the falling edge, predict, check after
  // the rising edge.
  task automatic applyStimulus(input logic stall, input logic br,
                               input logic [31:0] tgt, input string tag);
    @(negedge clk);
    Stall        = stall;
    BranchTaken  = br;
    BranchTarget = tgt;
    xmode        = stall | br;
    if (br) begin
      m_pc    = (tgt / 4) * 4;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
    end else if (!stall) begin
      m_instr = mem_word(m_pc);
      m_pc4   = m_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b1;
    Stall        = 1'b1;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h0000_0040;
    xmode        = 1'b1;
    modelReset();

    // reset with stall and redirect asserted: both must be ignored
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_async");
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_held");

    rst_n       = 1'b1;
    Stall       = 1'b0;
    BranchTaken = 1'b0;
    xmode       = 1'b0;

    applyStimulus(0, 0, 32'h0, "free1");
    checkValue("free1_instr", IFID_Instr, 32'h2008_0005);
    applyStimulus(0, 0, 32'h0, "free2");
    checkValue("free2_addr", Address, 32'h0000_0008);
    checkValue("free2_pc4", IFID_PCPlus4, 32'h0000_0008);

    applyStimulus(1, 0, 32'h0, "stall1");
    applyStimulus(1, 0, 32'h0, "stall2");
    checkValue("stall_addr", Address, 32'h0000_0008);
    checkValue("stall_instr", IFID_Instr, 32'h2009_0003);
    applyStimulus(0, 0, 32'h0, "resume");
    checkValue("resume_instr", IFID_Instr, 32'h0109_5020);
    checkValue("resume_addr", Address, 32'h0000_000C);

    applyStimulus(1, 1, 32'h0000_0004, "br_over_stall");
    checkValue("br_addr", Address, 32'h0000_0004);
    checkValue("br_valid", {31'd0, IFID_Valid}, 32'd0);
    applyStimulus(0, 0, 32'h0, "after_br");
    checkValue("after_br_instr", IFID_Instr, 32'h2009_0003);
    checkValue("after_br_valid", {31'd0, IFID_Valid}, 32'd1);

    applyStimulus(0, 1, 32'h0000_000B, "br_misaligned");
    checkValue("misaligned_addr", Address, 32'h0000_0008);

    applyStimulus(0, 1, 32'hFFFF_FFFF, "br_top");
    applyStimulus(0, 0, 32'h0, "wrap");
    checkValue("wrap_addr", Address, 32'h0000_0000);
    checkValue("wrap_pc4", IFID_PCPlus4, 32'h0000_0000);

    applyStimulus(0, 1, 32'h0000_0100, "br_first");
    applyStimulus(1, 1, 32'h0000_0206, "br_second");
    checkValue("double_br_addr", Address, 32'h0000_0204);

    applyStimulus(0, 1, 32'h0000_0010, "br_to_10");

    // reset pulse between edges with a pending stall and redirect
    #2;
    Stall        = 1'b1;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h0000_0080;
    xmode        = 1'b1;
    rst_n        = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_async");
    @(posedge clk); #1;
    checkOutput("midreset_edge");
    rst_n       = 1'b1;
    Stall       = 1'b0;
    BranchTaken = 1'b0;
    xmode       = 1'b0;
    applyStimulus(0, 0, 32'h0, "restart");
    checkValue("restart_addr", Address, 32'h0000_0004);
    checkValue("restart_instr", IFID_Instr, 32'h2008_0005);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic        s;
      logic        b;
      logic [31:0] t;
      s = ($urandom % 4) == 0;
      b = ($urandom % 6) == 0;
      if ($urandom % 2 == 0) t = $urandom_range(0, 7) * 4 + ($urandom % 4);
      else                   t = $urandom;
      applyStimulus(s, b, t, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded at reset.
- REQ-002 Parameter NOP_WORD, default 32'h00000000: instruction word used for bubbles.
- REQ-003 clk  input  1: single clock; all state updates on the rising edge.
- REQ-004 rst_n  input  1: reset, asynchronous and active-low.
- REQ-005 Stall  input  1: hold the PC and the IF/ID register.
- REQ-006 BranchTaken  input  1: redirect fetch to BranchTarget.
- REQ-007 BranchTarget  input  32: redirect byte address.
- REQ-008 Address  output  32: current PC, driven to the instruction memory.
- REQ-009 Instruction  input  32: word returned combinationally by the instruction memory for Address.
- REQ-010 IFID_Instr  output  32: registered fetched instruction.
- REQ-011 IFID_PCPlus4  output  32: registered PC+4 of IFID_Instr.
- REQ-012 IFID_Valid  output  1: IFID_Instr holds a real instruction, not a bubble.

Function
- REQ-013 Address SHALL equal the PC register directly, with no combinational path from any input.
- REQ-014 Normal cycle (no BranchTaken, no Stall) SHALL do all of the following:
  - PC <= PC+4.
  - IFID_Instr <= Instruction.
  - IFID_PCPlus4 <= PC+4.
  - IFID_Valid <= 1.
- REQ-015 Fetch-to-IF/ID latency SHALL be exactly one cycle: the word at Address in cycle N appears on IFID_Instr in cycle N+1.
- REQ-016 Stall=1 with BranchTaken=0 SHALL hold the PC, IFID_Instr, IFID_PCPlus4 and IFID_Valid unchanged.
- REQ-017 BranchTaken=1 SHALL override Stall and do all of the following:
  - PC <= {BranchTarget[31:2], 2'b00}.
  - IFID_Instr <= NOP_WORD.
  - IFID_PCPlus4 <= 0.
  - IFID_Valid <= 0 (one bubble).
- REQ-018 A misaligned BranchTarget (bits [1:0] != 0) SHALL be word-aligned by clearing bits [1:0]; no error output exists.
- REQ-019 PC+4 SHALL be 32-bit modular: 32'hFFFFFFFC advances to 32'h00000000 with no flag.
- REQ-020 Consecutive BranchTaken cycles SHALL each redirect; the last target wins and IFID_Valid stays 0.
- REQ-021 X on Instruction while Stall=1 or BranchTaken=1 SHALL NOT propagate to IF/ID outputs.

Reset
- REQ-022 rst_n=0 SHALL immediately, independent of clk, set:
  - PC = RESET_PC.
  - IFID_Instr = NOP_WORD.
  - IFID_PCPlus4 = 0.
  - IFID_Valid = 0.
- REQ-023 Reset asserted mid-operation SHALL discard any pending stall or redirect; the first edge after rst_n rises SHALL fetch from RESET_PC.
- REQ-024 Stall and BranchTaken SHALL be ignored while rst_n=0.

Structure
- REQ-025 RESET_PC default, NOP_WORD and the instruction width of 32 SHALL live in the shared MIPS constants include file used by the instruction memory and later pipeline stages.
- REQ-026 The PC register with its next-PC mux SHALL be one sub-module, pc_register; the IF/ID register SHALL stay inline in fetch_stage.
- REQ-027 fetch_stage SHALL NOT instantiate the instruction memory; the memory is connected beside it at the top level via Address/Instruction.

Verification (memory preloaded: word0=32'h20080005, word1=32'h20090003, word2=32'h01095020, word3=32'hAC0A0000, word4=32'h08000000)
- REQ-028 Reset release, 5 free cycles:
  - Address steps 0,4,8,C,10.
  - IFID_Instr lags one cycle: 20080005, 20090003, 01095020, AC0A0000.
  - IFID_PCPlus4 = 4,8,C,10.
  - IFID_Valid = 1 from the second edge.
- REQ-029 Stall=1 for 2 cycles at Address=8: Address holds 8, IFID_Instr holds 20090003; resume yields 01095020.
- REQ-030 BranchTaken=1, BranchTarget=32'h00000004 together with Stall=1 at Address=C:
  - Next cycle Address=4, IFID_Valid=0, IFID_Instr=0.
  - Following cycle IFID_Instr=20090003, IFID_Valid=1.
- REQ-031 BranchTarget=32'h0000000B: Address becomes 32'h00000008.
- REQ-032 Force PC to 32'hFFFFFFFC via branch, then one free cycle: Address=0, IFID_PCPlus4=0.
- REQ-033 rst_n pulsed low between clock edges at Address=10:
  - Outputs return to the REQ-022 values before the next edge.
  - After release, fetch restarts at 0.
